pixel_write_arbiter: RTL and testbench
======================================

# pixel_write_arbiter

Merges 32-bit pixel-memory write requests from two drawing generators (the rectangle generator and a second drawing client) into a single write stream for the frame-buffer memory port. Client ports use the generator-side rts/rtr handshake with {data, addr, wben}. Accepted requests pass through a small FIFO that absorbs memory stalls, such as display-fetch priority cycles. The block sits directly downstream of the generators and upstream of the frame-buffer RAM.

## Interface
Parameters:
- FIFO_DEPTH, 4, entries in the write FIFO; must be a power of two, minimum 2.
- ADDR_W, 16, word-address width; 32-bit words.

Ports:
- clk  input  1  clock.
- rst_  input  1  reset, asynchronous, active-low.
- p0_data  input  32  client 0 write data.
- p0_addr  input  ADDR_W  client 0 word address.
- p0_wben  input  4  client 0 byte enables; bit i enables data[8i+7:8i].
- p0_rts  input  1  client 0 request valid.
- p0_rtr  output  1  client 0 accepted this cycle.
- p1_data, p1_addr, p1_wben, p1_rts, p1_rtr: same as p0_*, for client 1.
- mem_stall  input  1  memory port unavailable this cycle.
- mem_we  output  1  write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  write data.
- mem_wben  output  4  byte enables.
- idle  output  1  FIFO empty and no client rts.

## Operation
- Transfer on port i: pi_rts & pi_rtr. Entries are pushed as {addr, wben, data}.
- Grant is combinational from current rts, the round-robin pointer `last`, and the registered FIFO count.
  - No grant when the FIFO is full. A pop in the same cycle does not enable a push.
  - Only one rts asserted: that port is granted.
  - Both rts asserted: the port other than `last` is granted.
- `last` updates to the served port on each transfer. Its reset value is 1, so port 0 wins the first contention.
- pi_rtr equals grant_i. Clients may hold rts with stable fields until rtr is seen. rtr never depends on the rts of the other port except through the arbitration rule.
- Zero-enable requests: a transfer with wben==0 is accepted (rtr asserted, `last` updated) but not pushed.
- Memory side:
  - mem_we = (count != 0) & !mem_stall, combinational.
  - mem_addr, mem_wdata and mem_wben are driven from the FIFO head whenever count != 0. They are 0 when the FIFO is empty.
  - Pop occurs when mem_we is high.
- Ordering:
  - Writes from the same port retire in acceptance order.
  - Cross-port ordering follows grant order.
  - No address coalescing or hazard checking.

## Timing
- Reset values:
  - count 0, read and write pointers 0, `last`=1.
  - mem_we 0, mem_addr/mem_wdata/mem_wben 0.
  - p0_rtr/p1_rtr 0 unless the corresponding rts is high after reset release.
  - idle 1 with no rts.
- Latency: a transfer in cycle N gives mem_we in cycle N+1 at the earliest; there is no combinational rts-to-mem_we path.
- Throughput: 1 write per cycle sustained when mem_stall is low.
- FIFO full:
  - rtr stays low for both ports until count drops.
  - With the FIFO full and mem_stall low, accept resumes the cycle after the pop.
- Simultaneous push and pop with count not full: count is unchanged.
- mem_stall held high: the FIFO fills to FIFO_DEPTH, then both rtr are low. No entries are lost or duplicated.
- Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-operation:
  - The FIFO contents are discarded and outputs return immediately to reset values.
  - In-flight requests are not retired.

## Structure
- Shared graphics package holds:
  - the memory word width (32)
  - the byte-enable width (4)
  - default ADDR_W (16)
  - the request bundle layout {addr, wben, data}, 52 bits at the defaults
- The FIFO is a natural sub-module, `sync_fifo`, parameterised on width and depth. It is reusable by other pipeline stages and exposes full, empty and count.
- The arbiter logic (grant, `last`, zero-wben drop) stays in the top module.

## Test plan
- Single write: p0 sends addr 0x0123, data 0x00AA0000, wben 0x4. Then p0_rtr=1 for one cycle, and the next cycle mem_we=1 with the same fields. idle returns to 1 afterwards.
- Contention: p0 and p1 assert rts continuously with distinct addresses. Grants alternate p0, p1, p0, p1, and mem_we stays at one write per cycle.
- Backpressure: mem_stall=1 while p0 streams addresses 0..7. After 4 accepts, p0_rtr=0. Releasing the stall retires addresses 0..7 in order with no gaps or duplicates.
- Zero-enable drop: p1 sends wben 0x0 then wben 0xF at address 0x0010. Both are accepted, but only the 0x0010 write appears on mem_we.
- Full plus pop: FIFO full, mem_stall falls, and p0_rts=1. mem_we pops in cycle N, p0_rtr=1 in cycle N+1, and count returns to 4.
- Reset mid-stream: rst_ is asserted with 3 entries queued. mem_we drops immediately, count is 0, and after release the first contention is won by p0.

Source files
------------

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared graphics definitions: memory word layout and the write-request bundle.
package pixel_write_arbiter_pkg;

  localparam int MEM_W      = 32;  // frame-buffer word width
  localparam int BE_W       = 4;   // one enable per byte of the word
  localparam int DEF_ADDR_W = 16;  // default word-address width

  // Request bundle as stored in the write FIFO, MSB first: {addr, wben, data}.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [BE_W-1:0]       wben;
    logic [MEM_W-1:0]      data;
  } pix_req_t;

  // Bundle width for an arbitrary address width.
  function automatic int req_width(input int addr_w);
    return addr_w + BE_W + MEM_W;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Two-client round-robin pixel write arbiter feeding the frame-buffer port
// through a small FIFO that rides out memory stalls.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [MEM_W-1:0]  p0_data,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [BE_W-1:0]   p0_wben,
  input  logic              p0_rts,
  output logic              p0_rtr,
  input  logic [MEM_W-1:0]  p1_data,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [BE_W-1:0]   p1_wben,
  input  logic              p1_rts,
  output logic              p1_rtr,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic [BE_W-1:0]   mem_wben,
  output logic              idle
);

  localparam int REQ_W = ADDR_W + BE_W + MEM_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            rts, gnt;
  logic [1:0][REQ_W-1:0] req;
  logic [REQ_W-1:0]      win_req, head;
  logic                  last;   // port served by the most recent transfer
  logic                  xfer, push, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign rts    = {p1_rts, p0_rts};
  assign req[0] = {p0_addr, p0_wben, p0_data};
  assign req[1] = {p1_addr, p1_wben, p1_data};

  // Grant: nothing while full (registered count), else round-robin on contention.
  always_comb begin
    gnt = 2'b00;
    if (!fifo_full) begin
      case (rts)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign p0_rtr  = gnt[0];
  assign p1_rtr  = gnt[1];
  assign xfer    = |gnt;
  assign win_req = req[gnt[1]];
  // Zero-enable writes are handshaken but never reach memory.
  assign push    = xfer & (|win_req[MEM_W +: BE_W]);

  // Remember who was served; reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)     last <= 1'b1;
    else if (xfer) last <= gnt[1];
  end

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (push),
    .push_data (win_req),
    .pop       (mem_we),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_we = ~fifo_empty & ~mem_stall;
  assign idle   = (fifo_count == '0) & ~p0_rts & ~p1_rts;

  // Present the FIFO head to memory; force zeros when there is nothing queued.
  always_comb begin
    mem_addr  = '0;
    mem_wben  = '0;
    mem_wdata = '0;
    if (!fifo_empty) begin
      mem_addr  = head[MEM_W+BE_W +: ADDR_W];
      mem_wben  = head[MEM_W +: BE_W];
      mem_wdata = head[0 +: MEM_W];
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed literal checks plus a randomized run
// compared every cycle against a queue-based model of the arbiter.
module tb_pixel_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_;
  logic [31:0]   p0_data, p1_data;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [3:0]    p0_wben, p1_wben;
  logic          p0_rts, p1_rts, p0_rtr, p1_rtr;
  logic          mem_stall, mem_we, idle;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wben;

  int nvec = 0;
  int nerr = 0;

  pixel_write_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_(rst_),
    .p0_data(p0_data), .p0_addr(p0_addr), .p0_wben(p0_wben), .p0_rts(p0_rts), .p0_rtr(p0_rtr),
    .p1_data(p1_data), .p1_addr(p1_addr), .p1_wben(p1_wben), .p1_rts(p1_rts), .p1_rtr(p1_rtr),
    .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wben(mem_wben), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Queue of {addr, wben, data} words waiting for memory, plus who was served last.
  logic [51:0] q[$];
  int          m_last = 1;

  always @(negedge clk) begin
    logic [51:0] h;
    int          win;
    logic        we;
    if (!rst_) begin
      q.delete();
      m_last = 1;
    end else begin
      // Arbitration rule: no one if FIFO full; lone requester wins; else not-last wins.
      win = -1;
      if (q.size() < DEPTH) begin
        if (p0_rts && p1_rts) win = (m_last == 0) ? 1 : 0;
        else if (p0_rts)      win = 0;
        else if (p1_rts)      win = 1;
      end
      we = (q.size() != 0) && !mem_stall;
      h  = (q.size() != 0) ? q[0] : 52'd0;
      chk("m_p0_rtr", p0_rtr, win == 0);
      chk("m_p1_rtr", p1_rtr, win == 1);
      chk("m_mem_we", mem_we, we);
      chk("m_addr",   mem_addr, h[51:36]);
      chk("m_wben",   mem_wben, h[35:32]);
      chk("m_wdata",  mem_wdata, h[31:0]);
      chk("m_idle",   idle, (q.size() == 0) && !p0_rts && !p1_rts);
      // What the coming rising edge does.
      if (we) void'(q.pop_front());
      if (win == 0 && p0_wben != 0) q.push_back({p0_addr, p0_wben, p0_data});
      if (win == 1 && p1_wben != 0) q.push_back({p1_addr, p1_wben, p1_data});
      if (win >= 0) m_last = win;
    end
  end

  task automatic drain();
    p0_rts = 0; p1_rts = 0; mem_stall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (idle) break;
      tick();
    end
    chk("drain_idle", idle, 1'b1);
    tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int acc, got;
    rst_ = 0; mem_stall = 0;
    p0_rts = 0; p1_rts = 0;
    p0_data = 0; p0_addr = 0; p0_wben = 0;
    p1_data = 0; p1_addr = 0; p1_wben = 0;
    tick(); tick();
    rst_ = 1;
    @(negedge clk);
    chk("rst_idle", idle, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_rtr", {p0_rtr, p1_rtr}, 2'b00);
    tick();

    // Contention from reset: p0 first, then alternate, one write per cycle.
    p0_rts = 1; p0_addr = 16'h0100; p0_wben = 4'hF; p0_data = 32'h1111_0000;
    p1_rts = 1; p1_addr = 16'h0200; p1_wben = 4'hF; p1_data = 32'h2222_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_p0_rtr", p0_rtr, (k % 2) == 0);
      chk("cont_p1_rtr", p1_rtr, (k % 2) == 1);
      if (k > 0) begin
        chk("cont_we", mem_we, 1'b1);
        chk("cont_addr", mem_addr, (k % 2) ? 16'h0100 : 16'h0200);
      end
      tick();
    end
    drain();

    // Single write.
    p0_rts = 1; p0_addr = 16'h0123; p0_data = 32'h00AA_0000; p0_wben = 4'h4;
    @(negedge clk);
    chk("single_rtr", p0_rtr, 1'b1);
    tick(); p0_rts = 0;
    @(negedge clk);
    chk("single_we", mem_we, 1'b1);
    chk("single_addr", mem_addr, 16'h0123);
    chk("single_data", mem_wdata, 32'h00AA_0000);
    chk("single_wben", mem_wben, 4'h4);
    tick();
    @(negedge clk);
    chk("single_idle", idle, 1'b1);
    chk("single_we_off", mem_we, 1'b0);
    tick();

    // Zero-enable drop: both handshaken, only the second written.
    p1_rts = 1; p1_addr = 16'h0010; p1_wben = 4'h0; p1_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("zero_rtr_a", p1_rtr, 1'b1);
    tick(); p1_wben = 4'hF; p1_data = 32'h1234_5678;
    @(negedge clk);
    chk("zero_rtr_b", p1_rtr, 1'b1);
    chk("zero_dropped", mem_we, 1'b0);
    tick(); p1_rts = 0;
    @(negedge clk);
    chk("zero_we", mem_we, 1'b1);
    chk("zero_wben", mem_wben, 4'hF);
    chk("zero_data", mem_wdata, 32'h1234_5678);
    tick();
    @(negedge clk);
    chk("zero_once", mem_we, 1'b0);
    tick();

    // Backpressure: stall while p0 streams 0..7; release and check in-order retire.
    mem_stall = 1; p0_rts = 1; p0_addr = 0; p0_wben = 4'hF; p0_data = 32'hCAFE_0000;
    acc = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (c == 4 || c == 5) chk("bp_full_rtr", p0_rtr, 1'b0);
      if (mem_we) begin
        chk("bp_order", mem_addr, 16'(got));
        got++;
      end
      if (p0_rtr) acc++;
      tick();
      if (acc >= 8) p0_rts = 0;
      else p0_addr = 16'(acc);
      if (c == 6) mem_stall = 0;
    end
    chk("bp_count", got, 8);
    drain();

    // Full plus pop: accept resumes the cycle after the pop.
    mem_stall = 1; p0_rts = 1; p0_addr = 16'h0300;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!p0_rtr) break;
      tick();
      p0_addr = p0_addr + 1;
    end
    chk("fp_filled", p0_rtr, 1'b0);
    tick(); mem_stall = 0;
    @(negedge clk);
    chk("fp_pop", mem_we, 1'b1);
    chk("fp_no_rtr", p0_rtr, 1'b0);
    tick();
    @(negedge clk);
    chk("fp_rtr", p0_rtr, 1'b1);
    tick();
    drain();

    // Reset mid-stream with 3 entries queued.
    mem_stall = 1; p0_rts = 1; p0_addr = 16'h0005;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      if (p0_rtr) acc++;
      tick();
      p0_addr = 16'h0005 + 16'(acc);
    end
    p0_rts = 0;
    @(negedge clk);
    chk("mr_queued", idle, 1'b0);
    tick();
    rst_ = 0;
    #1;
    chk("mr_we", mem_we, 1'b0);
    chk("mr_addr", mem_addr, 16'h0);
    chk("mr_wben", mem_wben, 4'h0);
    chk("mr_idle", idle, 1'b1);
    mem_stall = 0;
    @(negedge clk);
    chk("mr_we_hold", mem_we, 1'b0);
    tick();
    rst_ = 1;
    p0_rts = 1; p1_rts = 1;
    @(negedge clk);
    chk("mr_first_p0", {p0_rtr, p1_rtr}, 2'b10);
    tick();
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      mem_stall = ($urandom_range(0, 9) < 3);
      p0_rts  = ($urandom_range(0, 9) < 6);
      p1_rts  = ($urandom_range(0, 9) < 6);
      p0_addr = 16'($urandom); p1_addr = 16'($urandom);
      p0_data = $urandom;      p1_data = $urandom;
      p0_wben = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      p1_wben = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
